// File: rtl/edge_detect_multi_if.sv
// edge_detect_multi_if: channel-side bundle for edge_detect_multi (inputs, mode, levels, pulses, flags).
interface edge_detect_multi_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0]   edge_i;
  logic [2*CHANNELS-1:0] mode_i;
  logic [CHANNELS-1:0]   clear_i;
  logic [CHANNELS-1:0]   level_o;
  logic [CHANNELS-1:0]   pulse_o;
  logic [CHANNELS-1:0]   event_o;
  logic                  irq_o;
  modport master (
    output edge_i, mode_i, clear_i,
    input  level_o, pulse_o, event_o, irq_o
  );
  modport slave (
    input  edge_i, mode_i, clear_i,
    output level_o, pulse_o, event_o, irq_o
  );
endinterface

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, glitch filter and edge-to-pulse converter.
// Sticky event flags, write-one-to-clear and irq_o exist only when EDGE_DET_STICKY_EN is defined.
module edge_detect_multi #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  edge_detect_multi_if.slave bus
);
  localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(FILTER_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
  logic [CW-1:0]          r_cnt  [CHANNELS];
  logic [CHANNELS-1:0]    r_lvl;
  logic [CHANNELS-1:0]    r_pulse;
  logic [CHANNELS-1:0]    w_s;
  logic [CHANNELS-1:0]    w_take;
  logic [CHANNELS-1:0]    w_pulse;
  // w_take is only high when s differs from L, so toggling L applies the new level
  always_comb begin
    w_s     = '0;
    w_take  = '0;
    w_pulse = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_s[n]     = r_sync[n][SYNC_STAGES-1];
      w_take[n]  = (w_s[n] != r_lvl[n]) && (r_cnt[n] == C_LAST);
      w_pulse[n] = w_take[n] && (w_s[n] ? bus.mode_i[2*n] : bus.mode_i[2*n+1]);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_sync[n] <= '0;
        r_cnt[n]  <= '0;
      end
      r_lvl   <= '0;
      r_pulse <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_sync[n] <= {r_sync[n][SYNC_STAGES-2:0], bus.edge_i[n]};
        r_cnt[n]  <= (w_s[n] == r_lvl[n] || w_take[n]) ? '0 : r_cnt[n] + CW'(1);
      end
      r_lvl   <= r_lvl ^ w_take;
      r_pulse <= w_pulse;
    end
  end
  assign bus.level_o = r_lvl;
  assign bus.pulse_o = r_pulse;
`ifdef EDGE_DET_STICKY_EN
  logic [CHANNELS-1:0] r_event;
  // set dominates clear so an edge coinciding with a clear is never lost
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_event <= '0;
    else         r_event <= w_pulse | (r_event & ~bus.clear_i);
  end
  assign bus.event_o = r_event;
  assign bus.irq_o   = |r_event;
`else
  logic w_unused_clear;
  assign w_unused_clear = ^bus.clear_i;
  assign bus.event_o    = '0;
  assign bus.irq_o      = 1'b0;
`endif
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed-vector bench for edge_detect_multi at default parameters.
module tb_edge_detect_multi;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
`ifdef EDGE_DET_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  edge_detect_multi_if #(.CHANNELS(8)) bus();
  edge_detect_multi #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    int bad;
    bus.edge_i  = '0;
    bus.mode_i  = '0;
    bus.clear_i = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.level_o, bus.pulse_o, bus.event_o, bus.irq_o} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", {bus.level_o, bus.pulse_o, bus.event_o, bus.irq_o});
    end
    tick(2);
    rst_n = 1'b1;
    bus.mode_i = 16'hFFFF;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.pulse_o !== 8'h00 || bus.level_o !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_idle got %0d active cycles expected 0", bad);
    end
    bus.mode_i = '0;
  endtask
  task automatic test_rising();
    int np;
    bus.mode_i    = 16'h0001;
    bus.edge_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if (bus.level_o[0] !== 1'b0 || bus.pulse_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL rise_edge5 got lvl=%b pulse=%b expected 0 0", bus.level_o[0], bus.pulse_o[0]);
        end
      end
      if (k == 6) begin
        checks++;
        if (bus.level_o[0] !== 1'b1 || bus.pulse_o[0] !== 1'b1) begin
          errors++;
          $display("FAIL rise_edge6 got lvl=%b pulse=%b expected 1 1", bus.level_o[0], bus.pulse_o[0]);
        end
      end
      if (k == 7) begin
        checks++;
        if (bus.level_o[0] !== 1'b1 || bus.pulse_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL rise_edge7 got lvl=%b pulse=%b expected 1 0", bus.level_o[0], bus.pulse_o[0]);
        end
      end
    end
    bus.edge_i[0] = 1'b0;
    np = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      np += int'(bus.pulse_o[0]);
    end
    checks++;
    if (np !== 0 || bus.level_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_fall_nopulse got pulses=%0d lvl=%b expected 0 0", np, bus.level_o[0]);
    end
    bus.mode_i = '0;
  endtask
  task automatic test_async_reset();
    int bad;
    bus.mode_i    = 16'h0001;
    bus.edge_i[0] = 1'b1;
    tick(6);
    bus.edge_i[0] = 1'b0;
    tick(4);
    checks++;
    if (bus.level_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got lvl=%b expected 1", bus.level_o[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.level_o, bus.pulse_o, bus.event_o, bus.irq_o} !== 25'd0) begin
      errors++;
      $display("FAIL areset_outputs got %h expected 0", {bus.level_o, bus.pulse_o, bus.event_o, bus.irq_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.pulse_o[0] !== 1'b0 || bus.level_o[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL areset_release got %0d active cycles expected 0", bad);
    end
    bus.mode_i = '0;
  endtask
  task automatic test_glitch();
    int np;
    int nl;
    bus.mode_i    = 16'h0004;
    bus.edge_i[1] = 1'b1;
    np = 0;
    nl = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) bus.edge_i[1] = 1'b0;
      tick();
      np += int'(bus.pulse_o[1]);
      nl += int'(bus.level_o[1]);
    end
    checks++;
    if (np !== 0 || nl !== 0) begin
      errors++;
      $display("FAIL glitch_3cyc got pulses=%0d lvl_high=%0d expected 0 0", np, nl);
    end
    bus.edge_i[1] = 1'b1;
    np = 0;
    nl = 0;
    for (int k = 0; k < 18; k++) begin
      if (k == 4) bus.edge_i[1] = 1'b0;
      tick();
      np += int'(bus.pulse_o[1]);
      nl += int'(bus.level_o[1]);
    end
    checks++;
    if (np !== 1 || nl !== 4 || bus.level_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_4cyc got pulses=%0d lvl_high=%0d lvl=%b expected 1 4 0", np, nl, bus.level_o[1]);
    end
    bus.mode_i = '0;
  endtask
  task automatic test_modes();
    int cnt [4];
    int lvl_bad;
    int consec;
    int lvl_hi;
    logic [3:0] prev;
    cnt     = '{0, 0, 0, 0};
    lvl_bad = 0;
    consec  = 0;
    lvl_hi  = 0;
    prev    = '0;
    bus.mode_i      = 16'h00E4;
    bus.edge_i[3:0] = 4'hF;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) bus.edge_i[3:0] = 4'h0;
      tick();
      for (int c = 0; c < 4; c++) cnt[c] += int'(bus.pulse_o[c]);
      if (bus.level_o[3:0] !== 4'h0 && bus.level_o[3:0] !== 4'hF) lvl_bad++;
      if (bus.level_o[3:0] === 4'hF) lvl_hi++;
      if ((bus.pulse_o[3:0] & prev) !== 4'h0) consec++;
      prev = bus.pulse_o[3:0];
    end
    checks++;
    if (cnt[0] !== 0 || cnt[1] !== 1 || cnt[2] !== 1 || cnt[3] !== 2) begin
      errors++;
      $display("FAIL mode_counts got %0d %0d %0d %0d expected 0 1 1 2", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    checks++;
    if (lvl_bad !== 0 || lvl_hi !== 10) begin
      errors++;
      $display("FAIL mode_levels got mixed=%0d high=%0d expected 0 10", lvl_bad, lvl_hi);
    end
    checks++;
    if (consec !== 0) begin
      errors++;
      $display("FAIL mode_consecutive got %0d expected 0", consec);
    end
    bus.mode_i = '0;
  endtask
  task automatic test_sticky();
    bus.clear_i = '1;
    tick();
    bus.clear_i = '0;
    checks++;
    if (bus.event_o !== 8'h00 || bus.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear_all got ev=%h irq=%b expected 00 0", bus.event_o, bus.irq_o);
    end
    bus.mode_i    = 16'h0030;
    bus.edge_i[2] = 1'b1;
    tick(6);
    checks++;
    if (bus.pulse_o[2] !== 1'b1 || bus.event_o[2] !== STICKY || bus.irq_o !== STICKY) begin
      errors++;
      $display("FAIL sticky_set got pulse=%b ev=%b irq=%b expected 1 %b %b", bus.pulse_o[2], bus.event_o[2], bus.irq_o, STICKY, STICKY);
    end
    tick();
    checks++;
    if (bus.pulse_o[2] !== 1'b0 || bus.event_o[2] !== STICKY) begin
      errors++;
      $display("FAIL sticky_hold got pulse=%b ev=%b expected 0 %b", bus.pulse_o[2], bus.event_o[2], STICKY);
    end
    bus.edge_i[2] = 1'b0;
    tick(5);
    bus.clear_i[2] = 1'b1;
    tick();
    checks++;
    if (bus.pulse_o[2] !== 1'b1 || bus.event_o[2] !== STICKY || bus.irq_o !== STICKY) begin
      errors++;
      $display("FAIL sticky_set_wins got pulse=%b ev=%b irq=%b expected 1 %b %b", bus.pulse_o[2], bus.event_o[2], bus.irq_o, STICKY, STICKY);
    end
    tick();
    bus.clear_i[2] = 1'b0;
    checks++;
    if (bus.pulse_o[2] !== 1'b0 || bus.event_o[2] !== 1'b0 || bus.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear got pulse=%b ev=%b irq=%b expected 0 0 0", bus.pulse_o[2], bus.event_o[2], bus.irq_o);
    end
    bus.mode_i = '0;
  endtask
  initial begin
    test_reset();
    test_rising();
    test_async_reset();
    test_glitch();
    test_modes();
    test_sticky();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
